// File: rtl/fp_operand_collector.sv
// fp_operand_collector: feeds the FP execute unit with one instruction at a time.
// It latches the request, reads the non-r0 sources over one read port with
// 1-cycle latency, and presents op/operands/rd/tag to the FPU over valid/ready.
//   clk, rst            : clock, synchronous active-high reset
//   flush               : abort the in-flight instruction, highest priority
//   req_*               : instruction request handshake and fields
//   rf_rd_en/addr/data  : register-file read port (data valid the cycle after en)
//   fpu_*               : operand bundle and handshake towards the FPU
//   busy                : collector is not idle
`timescale 1ns/1ps
module fp_operand_collector #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned OP_W       = 4,
  parameter int unsigned TAG_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [OP_W-1:0]       req_op,
  input  logic [REG_ADDR_W-1:0] req_rs1,
  input  logic [REG_ADDR_W-1:0] req_rs2,
  input  logic [REG_ADDR_W-1:0] req_rd,
  input  logic [TAG_W-1:0]      req_tag,
  output logic                  rf_rd_en,
  output logic [REG_ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  output logic                  fpu_valid,
  input  logic                  fpu_ready,
  output logic [OP_W-1:0]       fpu_op,
  output logic [DATA_WIDTH-1:0] fpu_operand_a,
  output logic [DATA_WIDTH-1:0] fpu_operand_b,
  output logic [REG_ADDR_W-1:0] fpu_rd,
  output logic [TAG_W-1:0]      fpu_tag,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_RD_B  = 3'd2,
    S_LAST  = 3'd3,
    S_ISSUE = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [OP_W-1:0]         op_q, op_d;
  logic [REG_ADDR_W-1:0]   rs1_q, rs1_d;
  logic [REG_ADDR_W-1:0]   rs2_q, rs2_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  logic [DATA_WIDTH-1:0]   opa_q, opa_d;
  logic [DATA_WIDTH-1:0]   opb_q, opb_d;
  logic                    cap_vld_q, cap_vld_d;   // read data arrives this cycle
  logic                    cap_b_q, cap_b_d;       // 1: data belongs to operand B
  logic                    rd_en_q, rd_en_d;
  logic [REG_ADDR_W-1:0]   rd_addr_q, rd_addr_d;

  logic accept;
  logic handshake;
  logic need_a_in;
  logic need_b_in;
  logic need_b_q;
  logic dup_q;

  // Handshake-facing outputs; flush and reset suppress both in the same cycle.
  assign req_ready = (state_q == S_IDLE) && !flush && !rst;
  assign fpu_valid = (state_q == S_ISSUE) && !flush && !rst;
  assign accept    = req_valid && req_ready;
  assign handshake = fpu_valid && fpu_ready;

  // Source decode: r0 is never read, and a repeated source is read only once.
  assign need_a_in = (req_rs1 != '0);
  assign need_b_in = (req_rs2 != '0) && (req_rs2 != req_rs1);
  assign need_b_q  = (rs2_q != '0) && (rs2_q != rs1_q);
  assign dup_q     = (rs1_q == rs2_q) && (rs1_q != '0);

  assign busy          = (state_q != S_IDLE);
  assign rf_rd_en      = rd_en_q;
  assign rf_rd_addr    = rd_addr_q;
  assign fpu_op        = op_q;
  assign fpu_operand_a = opa_q;
  assign fpu_operand_b = opb_q;
  assign fpu_rd        = rd_q;
  assign fpu_tag       = tag_q;

  // Next-state, field latching and operand capture.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    tag_d     = tag_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    cap_vld_d = 1'b0;
    cap_b_d   = 1'b0;

    // Data for the strobe issued last cycle; a shared source also fills B.
    if (cap_vld_q) begin
      if (cap_b_q) begin
        opb_d = rf_rd_data;
      end else begin
        opa_d = rf_rd_data;
        if (dup_q) opb_d = rf_rd_data;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = req_op;
          rs1_d = req_rs1;
          rs2_d = req_rs2;
          rd_d  = req_rd;
          tag_d = req_tag;
          opa_d = '0;
          opb_d = '0;
          if (need_a_in)      state_d = S_RD_A;
          else if (need_b_in) state_d = S_RD_B;
          else                state_d = S_ISSUE;
        end
      end
      S_RD_A: begin
        cap_vld_d = 1'b1;
        cap_b_d   = 1'b0;
        state_d   = need_b_q ? S_RD_B : S_LAST;
      end
      S_RD_B: begin
        cap_vld_d = 1'b1;
        cap_b_d   = 1'b1;
        state_d   = S_LAST;
      end
      S_LAST:  state_d = S_ISSUE;
      S_ISSUE: if (handshake) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Flush wins: drop everything, including a read still in flight.
    if (flush) begin
      state_d   = S_IDLE;
      op_d      = '0;
      rs1_d     = '0;
      rs2_d     = '0;
      rd_d      = '0;
      tag_d     = '0;
      opa_d     = '0;
      opb_d     = '0;
      cap_vld_d = 1'b0;
      cap_b_d   = 1'b0;
    end
  end

  // Read strobe is registered, driven by the state being entered.
  always_comb begin
    rd_en_d   = (state_d == S_RD_A) || (state_d == S_RD_B);
    rd_addr_d = '0;
    if (state_d == S_RD_A)      rd_addr_d = rs1_d;
    else if (state_d == S_RD_B) rd_addr_d = rs2_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      tag_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      cap_vld_q <= 1'b0;
      cap_b_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      tag_q     <= tag_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      cap_vld_q <= cap_vld_d;
      cap_b_q   <= cap_b_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
    end
  end

endmodule

// File: tb/tb_fp_operand_collector.sv
// Testbench for fp_operand_collector: vector table plus flush/reset sequences,
// with a register-file model and a scoreboard of expected FPU issues.
`timescale 1ns/1ps
module tb_fp_operand_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [4:0]  req_rs1, req_rs2, req_rd;
  logic [3:0]  req_tag;
  logic        rf_rd_en;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        fpu_valid;
  logic        fpu_ready;
  logic [3:0]  fpu_op;
  logic [31:0] fpu_operand_a, fpu_operand_b;
  logic [4:0]  fpu_rd;
  logic [3:0]  fpu_tag;
  logic        busy;

  fp_operand_collector dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_tag(req_tag),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_op(fpu_op),
    .fpu_operand_a(fpu_operand_a), .fpu_operand_b(fpu_operand_b),
    .fpu_rd(fpu_rd), .fpu_tag(fpu_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register-file model: 1-cycle read latency, junk data when not reading.
  logic [31:0] regs [32];
  always @(posedge clk) rf_rd_data <= rf_rd_en ? regs[rf_rd_addr] : $urandom();

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op, tag;
    logic [31:0] a, b;
    int          lat, reads;
    logic [4:0]  ad0, ad1;
    int          stall;
  } vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic [3:0]  tag;
  } exp_t;

  vec_t vecs [8];
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [3:0] op, input logic [3:0] tag);
    req_valid = 1'b1;
    req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_op = op; req_tag = tag;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Run one vector to completion; called just after a negedge.
  task automatic run_vec(input vec_t v);
    int   n;
    int   lat;
    int   reads;
    logic seen;
    logic [4:0] addrs [2];
    exp_t e;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    e.op = v.op; e.a = v.a; e.b = v.b; e.rd = v.rd; e.tag = v.tag;
    sb.push_back(e);
    drive_req(v.rs1, v.rs2, v.rd, v.op, v.tag);
    reads = 0; seen = 1'b0; lat = 0; addrs[0] = '0; addrs[1] = '0;
    for (int c = 1; c <= 12 && !seen; c++) begin
      @(negedge clk);
      if (rf_rd_en) begin
        if (reads < 2) addrs[reads] = rf_rd_addr;
        reads++;
      end
      if (fpu_valid) begin seen = 1'b1; lat = c; end
    end
    chk("latency", 64'(lat), 64'(v.lat));
    chk("read_count", 64'(reads), 64'(v.reads));
    if (v.reads > 0) chk("read_addr0", 64'(addrs[0]), 64'(v.ad0));
    if (v.reads > 1) chk("read_addr1", 64'(addrs[1]), 64'(v.ad1));
    // Stall: everything held while fpu_ready is low.
    for (int s = 0; s < v.stall; s++) begin
      chk("stall_valid", 64'(fpu_valid), 64'd1);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      chk("stall_a", 64'(fpu_operand_a), 64'(v.a));
      chk("stall_b", 64'(fpu_operand_b), 64'(v.b));
      chk("stall_op_rd_tag", {51'd0, fpu_op, fpu_rd, fpu_tag}, {51'd0, v.op, v.rd, v.tag});
      @(negedge clk);
    end
    fpu_ready = 1'b1;
    if (sb.size() == 0) begin
      chk("sb_nonempty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk("hs_valid", 64'(fpu_valid), 64'd1);
      chk("hs_a", 64'(fpu_operand_a), 64'(e.a));
      chk("hs_b", 64'(fpu_operand_b), 64'(e.b));
      chk("hs_op", 64'(fpu_op), 64'(e.op));
      chk("hs_rd", 64'(fpu_rd), 64'(e.rd));
      chk("hs_tag", 64'(fpu_tag), 64'(e.tag));
    end
    @(posedge clk);
    #1 fpu_ready = 1'b0;
    @(negedge clk);
    chk("post_valid", 64'(fpu_valid), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_req_ready", 64'(req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);
    regs[0] = 32'hDEAD_BEEF;  // must never be read
    regs[1] = 32'h3F00_0000; regs[2] = 32'h4080_0000;
    regs[3] = 32'h4040_0000; regs[5] = 32'h4000_0000;
    regs[7] = 32'h3F80_0000; regs[9] = 32'hC000_0000;

    //            rs1 rs2 rd  op  tag  a             b             lat rd  a0  a1  stall
    vecs[0] = '{5'd3, 5'd5, 5'd10, 4'h1, 4'h1, 32'h4040_0000, 32'h4000_0000, 4, 2, 5'd3, 5'd5, 0};
    vecs[1] = '{5'd7, 5'd7, 5'd11, 4'h2, 4'h2, 32'h3F80_0000, 32'h3F80_0000, 3, 1, 5'd7, 5'd0, 0};
    vecs[2] = '{5'd0, 5'd0, 5'd12, 4'h3, 4'h3, 32'h0,         32'h0,         1, 0, 5'd0, 5'd0, 0};
    vecs[3] = '{5'd0, 5'd9, 5'd13, 4'h4, 4'h4, 32'h0,         32'hC000_0000, 3, 1, 5'd9, 5'd0, 0};
    vecs[4] = '{5'd9, 5'd0, 5'd14, 4'h5, 4'h5, 32'hC000_0000, 32'h0,         3, 1, 5'd9, 5'd0, 0};
    vecs[5] = '{5'd5, 5'd3, 5'd15, 4'h6, 4'h6, 32'h4000_0000, 32'h4040_0000, 4, 2, 5'd5, 5'd3, 5};
    vecs[6] = '{5'd0, 5'd0, 5'd16, 4'h7, 4'h7, 32'h0,         32'h0,         1, 0, 5'd0, 5'd0, 0};
    vecs[7] = '{5'd1, 5'd2, 5'd17, 4'h8, 4'h8, 32'h3F00_0000, 32'h4080_0000, 4, 2, 5'd1, 5'd2, 0};

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; fpu_ready = 1'b0;
    req_op = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0; req_tag = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_fpu_valid", 64'(fpu_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rf", {58'd0, rf_rd_en, rf_rd_addr}, 64'd0);
    chk("rst_fields", {fpu_operand_a, fpu_operand_b}, 64'd0);
    chk("rst_op_rd_tag", {51'd0, fpu_op, fpu_rd, fpu_tag}, 64'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Flush while in RD_B: late read data must be discarded.
    drive_req(5'd3, 5'd5, 5'd20, 4'h9, 4'h9);
    @(negedge clk);
    chk("fl_rda", {58'd0, rf_rd_en, rf_rd_addr}, {58'd0, 1'b1, 5'd3});
    @(negedge clk);
    chk("fl_rdb", {58'd0, rf_rd_en, rf_rd_addr}, {58'd0, 1'b1, 5'd5});
    flush = 1'b1;
    #1;
    chk("fl_req_ready", 64'(req_ready), 64'd0);
    chk("fl_fpu_valid", 64'(fpu_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fl_idle_ready", 64'(req_ready), 64'd1);
    chk("fl_idle_busy", 64'(busy), 64'd0);
    chk("fl_cleared", {fpu_operand_a, fpu_operand_b}, 64'd0);
    @(negedge clk);
    chk("fl_late_data", {fpu_operand_a, fpu_operand_b}, 64'd0);
    chk("fl_no_read", 64'(rf_rd_en), 64'd0);

    // Flush in ISSUE with fpu_ready high: no handshake, back to IDLE.
    drive_req(5'd0, 5'd0, 5'd21, 4'hA, 4'hA);
    @(negedge clk);
    chk("fi_issue", 64'(fpu_valid), 64'd1);
    fpu_ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("fi_valid", 64'(fpu_valid), 64'd0);
    chk("fi_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    fpu_ready = 1'b0;
    #1;
    chk("fi_busy", 64'(busy), 64'd0);
    chk("fi_req_ready2", 64'(req_ready), 64'd1);
    chk("fi_cleared", {51'd0, fpu_op, fpu_rd, fpu_tag}, 64'd0);
    @(negedge clk);

    // Reset while in LAST, then a normal 1/2 request.
    drive_req(5'd1, 5'd2, 5'd22, 4'hB, 4'hB);
    repeat (3) @(negedge clk);
    chk("rl_last", {62'd0, busy, rf_rd_en}, 64'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rl_req_ready", 64'(req_ready), 64'd1);
    chk("rl_valid_busy", {62'd0, fpu_valid, busy}, 64'd0);
    chk("rl_rf", {58'd0, rf_rd_en, rf_rd_addr}, 64'd0);
    chk("rl_operands", {fpu_operand_a, fpu_operand_b}, 64'd0);
    chk("rl_fields", {51'd0, fpu_op, fpu_rd, fpu_tag}, 64'd0);
    @(negedge clk);
    run_vec(vecs[7]);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
